// File: rtl/inc_counter_pkg.sv
// Shared definitions for the inc_counter loop/iteration counter.
// State encoding is fixed so that 2'd3 is the only illegal code.
package inc_counter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/inc_add.sv
// Combinational incrementer: S = A + STEP, with the carry out of the top bit exposed
// so the caller can compare at WIDTH+1 bits and never wrap silently.
module inc_add
  import inc_counter_pkg::*;
#(
  parameter int              WIDTH = 64,
  parameter longint unsigned STEP  = 1
) (
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] S,
  output logic             Co
);

  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

  logic [WIDTH:0] sum;

  assign sum     = {1'b0, A} + STEP_EXT;
  assign {Co, S} = sum;

endmodule

// File: rtl/inc_counter.sv
// Loadable up-counter: loads StartVal/Limit on Start, adds STEP per enabled cycle,
// clamps at Limit, pulses Done for one cycle, then idles or reloads (AUTO_RELOAD).
module inc_counter
  import inc_counter_pkg::*;
#(
  parameter int              WIDTH       = 64,
  parameter longint unsigned STEP        = 1,
  parameter bit              AUTO_RELOAD = 1'b0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] StartVal,
  input  logic [WIDTH-1:0] Limit,
  input  logic             En,
  input  logic             Abort,
  output logic [WIDTH-1:0] Q,
  output logic             Busy,
  output logic             Done,
  output logic             Ovf
);

  state_t state_reg, state_next;

  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] start_reg, start_next;
  logic [WIDTH-1:0] lim_reg, lim_next;
  logic             ovf_reg, ovf_next;
  logic             busy_reg, done_reg;

  logic [WIDTH-1:0] add_s;
  logic             add_co;
  logic [WIDTH:0]   sum;
  logic             at_limit;
  logic             over_limit;

  inc_add #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_add (
    .A  (q_reg),
    .S  (add_s),
    .Co (add_co)
  );

  // Compare at WIDTH+1 bits so a carry out always counts as reaching the limit.
  assign sum        = {add_co, add_s};
  assign at_limit   = (sum >= {1'b0, lim_reg});
  assign over_limit = (sum >  {1'b0, lim_reg});

  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
    start_next = start_reg;
    lim_next   = lim_reg;
    ovf_next   = ovf_reg;

    case (state_reg)
      S_IDLE: begin
        if (Start) begin
          start_next = StartVal;
          lim_next   = Limit;
          q_next     = StartVal;
          ovf_next   = 1'b0;
          state_next = (StartVal >= Limit) ? S_DONE : S_COUNT;
        end
      end

      S_COUNT: begin
        if (Abort) begin
          state_next = S_IDLE;
        end else if (En) begin
          if (at_limit) begin
            q_next     = lim_reg;
            ovf_next   = over_limit;
            state_next = S_DONE;
          end else begin
            q_next = add_s;
          end
        end
      end

      S_DONE: begin
        if (AUTO_RELOAD && !Abort) begin
          q_next     = start_reg;
          state_next = S_COUNT;
        end else begin
          state_next = S_IDLE;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  // Busy/Done are registered from the next state so they change on the same edge as Q.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg <= S_IDLE;
      q_reg     <= '0;
      start_reg <= '0;
      lim_reg   <= '0;
      ovf_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      start_reg <= start_next;
      lim_reg   <= lim_next;
      ovf_reg   <= ovf_next;
      busy_reg  <= (state_next == S_COUNT);
      done_reg  <= (state_next == S_DONE);
    end
  end

  assign Q    = q_reg;
  assign Busy = busy_reg;
  assign Done = done_reg;
  assign Ovf  = ovf_reg;

endmodule
